// File: rtl/vga_pkg.sv
// Screen geometry and the pixel record carried from the tile drawers to vga_adapter.
package vga_pkg;

  localparam int nX          = 10;
  localparam int nY          = 9;
  localparam int COLOR_DEPTH = 9;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef struct packed {
    logic [nX-1:0]          x;
    logic [nY-1:0]          y;
    logic [COLOR_DEPTH-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel queue: write at wptr on push, head shown combinationally at rptr.
// Caller guarantees no push when full and no pop when empty.
module pixel_fifo import vga_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  pixel_t                   din,
  output pixel_t                   dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  pixel_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin grant of four tile drawers into a pixel FIFO, drained one pixel per cycle to vga_adapter.
// Grant-to-write latency 2 cycles with the FIFO empty; a full FIFO withholds all grants.
module pixel_write_arbiter import vga_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*nX-1:0]           x_in,
  input  logic [N_REQ*nY-1:0]           y_in,
  input  logic [N_REQ*COLOR_DEPTH-1:0]  color_in,
  output logic [N_REQ-1:0]              gnt,
  output logic [nX-1:0]                 x,
  output logic [nY-1:0]                 y,
  output logic [COLOR_DEPTH-1:0]        color,
  output logic                          write,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam int          IW   = $clog2(N_REQ);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_idx, scan_idx;
  logic          found;
  logic          fifo_push, fifo_pop;
  pixel_t        push_pix, head_pix;
  pixel_t        out_q, out_d;
  logic          write_q, write_d;

  // Scan starts just after the last winner so the previous winner is considered last.
  always_comb begin
    gnt       = '0;
    grant_idx = last_q;
    scan_idx  = last_q;
    found     = 1'b0;
    if (fifo_count != FULL) begin
      for (int k = 1; k <= N_REQ; k++) begin
        scan_idx = last_q + IW'(k);
        if (req[scan_idx] && !found) begin
          found         = 1'b1;
          gnt[scan_idx] = 1'b1;
          grant_idx     = scan_idx;
        end
      end
    end
  end

  assign fifo_push = found;
  assign fifo_pop  = (fifo_count != '0);

  always_comb begin
    push_pix.x     = x_in[grant_idx*nX +: nX];
    push_pix.y     = y_in[grant_idx*nY +: nY];
    push_pix.color = color_in[grant_idx*COLOR_DEPTH +: COLOR_DEPTH];
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (push_pix),
    .dout     (head_pix),
    .count    (fifo_count)
  );

  always_comb begin
    last_d  = fifo_push ? grant_idx : last_q;
    write_d = fifo_pop;
    out_d   = fifo_pop ? head_pix : out_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      last_q  <= IW'(N_REQ - 1);
      out_q   <= '0;
      write_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      out_q   <= out_d;
      write_q <= write_d;
    end
  end

  assign x     = out_q.x;
  assign y     = out_q.y;
  assign color = out_q.color;
  assign write = write_q;
  assign busy  = (fifo_count != '0) || write_q;

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Receiving end of the tile pixel-write interface. It replaces the fixed time-slot multiplexing in front of vga_adapter.
- Four tile drawers raise req with a pixel. The block grants one requester per cycle, round-robin, and buffers accepted pixels in a FIFO.
- It drains the FIFO to the adapter's x/y/color/write port at one pixel per cycle.
- Drawers advance their scan only on gnt, so no pixel is lost or duplicated.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 in this revision).
- nX, 10, X coordinate width (640x480).
- nY, 9, Y coordinate width.
- COLOR_DEPTH, 9, colour bits per pixel.
- FIFO_DEPTH, 16, entries; power of two, minimum 2.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  reset.
- req  in  4  bit i = requester i presents a valid pixel.
- x_in  in  4*nX  requester i coordinate in bits [i*nX +: nX].
- y_in  in  4*nY  packed the same way as x_in.
- color_in  in  4*COLOR_DEPTH  packed the same way as x_in.
- gnt  out  4  one-hot or zero; bit i = requester i's pixel accepted this cycle.
- x  out  nX  to vga_adapter.x.
- y  out  nY  to vga_adapter.y.
- color  out  COLOR_DEPTH  to vga_adapter.color.
- write  out  1  to vga_adapter.write.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  high when fifo_count != 0 or write == 1.

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is CLOCK_50. On reset:
  - x = 0, y = 0, color = 0, write = 0, fifo_count = 0, busy = 0, gnt = 0.
  - FIFO read/write pointers = 0.
  - Round-robin pointer last = 3, so requester 0 has first priority.
- Reset mid-operation discards all buffered pixels and any pixel being presented. Drawers are reset by the same resetn.
- Grant (combinational from req, last, fifo_count):
  - If fifo_count == FIFO_DEPTH, gnt = 0. No pop-bypass: full blocks grants even if a pop occurs the same cycle.
  - Otherwise, scan indices last+1, last+2, last+3, last (mod 4). The first index with req set gets gnt.
  - A requester holds req and its data stable until it sees gnt; the bench checks this.
- Push: at the clock edge where gnt[i] = 1, write the packed entry {x_i, y_i, color_i} at wptr. Then wptr++ and last <= i.
- last is unchanged when no grant occurs.
- Pop / output stage (registered):
  - At each edge, if fifo_count != 0 (value before the edge), load the entry at rptr into x/y/color, set write <= 1, rptr++.
  - Otherwise write <= 0; x/y/color hold their last values.
- Simultaneous push and pop: fifo_count is unchanged; both pointers advance.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. fifo_count tracks occupancy 0..FIFO_DEPTH.
- Latency: req granted in cycle k with FIFO empty → write = 1 with that pixel in cycle k+2. Sustained throughput is 1 pixel per cycle.
- Ordering: output order equals grant order.
- Fairness: with all four req held, grants cycle 0,1,2,3,0,… No requester waits more than 3 granted cycles while the FIFO is not full.
- No error outputs; overflow and underflow are structurally impossible.

Decomposition:
- Shared package vga_pkg:
  - Constants nX, nY, COLOR_DEPTH, SCREEN_W = 640, SCREEN_H = 480.
  - Typedef pixel_t = packed struct {x, y, color}, width nX+nY+COLOR_DEPTH = 28.
- One natural sub-module: pixel_fifo (synchronous, single clock).
  - Ports: push, pop, din, dout, count.
  - Register array for storage; dout is read combinationally from rptr.
- Round-robin logic and the output register stay in pixel_write_arbiter.

Test Plan:
1. Reset, then req = 0001 with x_in[0] = 5, y_in[0] = 7, color_in[0] = 9'h1FF for one cycle → gnt = 0001 that cycle. Two cycles later write = 1 with x = 5, y = 7, color = 1FF, and fifo_count returns to 0.
2. req = 1111 held for 8 cycles with distinct pixels → gnt sequence 0001, 0010, 0100, 1000, repeated twice. Output order matches, and write stays high continuously from the 3rd cycle.
3. Fill: FIFO_DEPTH = 4 with the output stage forced to stall via a bench-only force on pop → fifo_count reaches 4, gnt = 0 while req = 1111. Releasing the stall resumes grants at the next cycle.
4. Wrap: stream 40 pixels from requester 2 only → 40 writes, in order, no duplicates. Pointers wrap at least twice.
5. Reset asserted while fifo_count = 6 → all outputs are 0 immediately (asynchronous reset). After release, no stale pixel appears on write.
6. Fairness under churn: req 0101 alternating with 1010 every cycle → each granted index is the nearest requesting index after the previously granted one. No starvation over 100 cycles.
